// File: rtl/mod_counter_mc_pkg.sv
// Shared constants for the multi-channel modulus counter.
// The optional per-channel tc event counter is enabled by MOD_COUNTER_MC_WRAP_CNT_EN.
package mod_counter_mc_pkg;

  localparam logic MODE_WRAP     = 1'b0;
  localparam logic MODE_SATURATE = 1'b1;

  localparam int WRAP_CNT_W = 16;

endpackage

// File: rtl/mod_counter_ch.sv
// One counter channel: load/enable/direction, wrap or saturate at 0..limit, 1-cycle registered count/tc.
// No backpressure. The optional tc event counter is enabled by MOD_COUNTER_MC_WRAP_CNT_EN.
module mod_counter_ch
  import mod_counter_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc
`ifdef MOD_COUNTER_MC_WRAP_CNT_EN
  ,
  output logic [WRAP_CNT_W-1:0] o_wrap_cnt
`endif
);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;

  logic w_above;
  logic w_at_hi;
  logic w_at_zero;
  logic w_tc_next;

  assign w_above   = (r_count > i_limit);
  assign w_at_hi   = (r_count == i_limit);
  assign w_at_zero = (r_count == '0);
  // A count stranded above a lowered limit is pulled back without flagging tc.
  assign w_tc_next = i_en && !w_above && (i_up ? w_at_hi : w_at_zero);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_count <= '0;
      r_tc    <= 1'b0;
    end else if (i_load) begin
      r_count <= (i_load_val > i_limit) ? i_limit : i_load_val;
      r_tc    <= 1'b0;
    end else if (i_en) begin
      r_tc <= w_tc_next;
      if (w_above) begin
        r_count <= i_limit;
      end else if (i_up) begin
        if (w_at_hi) r_count <= (i_mode == MODE_WRAP) ? '0 : i_limit;
        else         r_count <= r_count + 1'b1;
      end else begin
        if (w_at_zero) r_count <= (i_mode == MODE_WRAP) ? i_limit : '0;
        else           r_count <= r_count - 1'b1;
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign o_count = r_count;
  assign o_tc    = r_tc;

`ifdef MOD_COUNTER_MC_WRAP_CNT_EN
  logic [WRAP_CNT_W-1:0] r_wrap_cnt;

  always_ff @(posedge clk) begin
    if (!rstn || i_load) begin
      r_wrap_cnt <= '0;
    end else if (w_tc_next && (r_wrap_cnt != {WRAP_CNT_W{1'b1}})) begin
      r_wrap_cnt <= r_wrap_cnt + 1'b1;
    end
  end

  assign o_wrap_cnt = r_wrap_cnt;
`endif

endmodule

// File: rtl/mod_counter_mc.sv
// NCH independent programmable-modulus up/down counters sharing mode and limit; 1-cycle latency, no backpressure.
// Define MOD_COUNTER_MC_WRAP_CNT_EN to add the per-channel 16-bit wrap_cnt output.
module mod_counter_mc
  import mod_counter_mc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     limit,
  input  logic [NCH-1:0]       en,
  input  logic [NCH-1:0]       up,
  input  logic [NCH-1:0]       load,
  input  logic [NCH*WIDTH-1:0] load_val,
  output logic [NCH*WIDTH-1:0] count,
  output logic [NCH-1:0]       tc
`ifdef MOD_COUNTER_MC_WRAP_CNT_EN
  ,
  output logic [NCH*WRAP_CNT_W-1:0] wrap_cnt
`endif
);

  logic [WIDTH-1:0] w_count [NCH];
  logic             w_tc    [NCH];
`ifdef MOD_COUNTER_MC_WRAP_CNT_EN
  logic [WRAP_CNT_W-1:0] w_wrap_cnt [NCH];
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    mod_counter_ch #(
      .WIDTH (WIDTH)
    ) u_ch (
      .clk        (clk),
      .rstn       (rstn),
      .i_mode     (mode),
      .i_limit    (limit),
      .i_en       (en[g]),
      .i_up       (up[g]),
      .i_load     (load[g]),
      .i_load_val (load_val[g*WIDTH +: WIDTH]),
      .o_count    (w_count[g]),
      .o_tc       (w_tc[g])
`ifdef MOD_COUNTER_MC_WRAP_CNT_EN
      ,
      .o_wrap_cnt (w_wrap_cnt[g])
`endif
    );
  end

  always_comb begin
    count = '0;
    tc    = '0;
    for (int i = 0; i < NCH; i++) begin
      count[i*WIDTH +: WIDTH] = w_count[i];
      tc[i]                   = w_tc[i];
    end
  end

`ifdef MOD_COUNTER_MC_WRAP_CNT_EN
  always_comb begin
    wrap_cnt = '0;
    for (int i = 0; i < NCH; i++) begin
      wrap_cnt[i*WRAP_CNT_W +: WRAP_CNT_W] = w_wrap_cnt[i];
    end
  end
`endif

endmodule

// File: tb/tb_mod_counter_mc.sv
// Directed bench for mod_counter_mc (WIDTH=8, NCH=4) with hand-computed expectations.
module tb_mod_counter_mc;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;

  logic                 clk;
  logic                 rstn;
  logic                 mode;
  logic [WIDTH-1:0]     limit;
  logic [NCH-1:0]       en;
  logic [NCH-1:0]       up;
  logic [NCH-1:0]       load;
  logic [NCH*WIDTH-1:0] load_val;
  logic [NCH*WIDTH-1:0] count;
  logic [NCH-1:0]       tc;
`ifdef MOD_COUNTER_MC_WRAP_CNT_EN
  logic [NCH*16-1:0]    wrap_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  mod_counter_mc #(
    .WIDTH (WIDTH),
    .NCH   (NCH)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .mode     (mode),
    .limit    (limit),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .tc       (tc)
`ifdef MOD_COUNTER_MC_WRAP_CNT_EN
    ,
    .wrap_cnt (wrap_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs may be changed and outputs sampled afterwards.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] cnt(input int ch);
    return {24'd0, count[ch*WIDTH +: WIDTH]};
  endfunction

  initial begin
    logic [7:0] exp_seq [8];
    exp_seq = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd2};

    // Reset dominates load and en
    rstn = 1'b0; mode = 1'b0; limit = 8'd100;
    en = 4'hF; up = 4'hF; load = 4'hF; load_val = {4{8'h33}};
    step();
    chk("reset_count", count, 32'd0);
    chk("reset_tc", {28'd0, tc}, 32'd0);

    rstn = 1'b1; en = 4'h0; load = 4'h0;
    step();
    chk("hold_after_reset", count, 32'd0);

    // WRAP, limit 5, ch0 up
    mode = 1'b0; limit = 8'd5; en = 4'b0001; up = 4'b0001;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("wrap_up_count_%0d", i), cnt(0), {24'd0, exp_seq[i]});
      chk($sformatf("wrap_up_tc_%0d", i), {31'd0, tc[0]}, (exp_seq[i] == 8'd0) ? 32'd1 : 32'd0);
    end
    chk("idle_ch1", cnt(1), 32'd0);

    // SATURATE, limit 3, ch1 loaded to 2 then counts down
    en = 4'b0000; mode = 1'b1; limit = 8'd3;
    load = 4'b0010; load_val = 32'h0000_0200;
    step();
    chk("sat_load", cnt(1), 32'd2);
    chk("hold_ch0", cnt(0), 32'd2);
    load = 4'b0000; en = 4'b0010; up = 4'b0000;
    step(); chk("sat_dn_c0", cnt(1), 32'd1); chk("sat_dn_t0", {31'd0, tc[1]}, 32'd0);
    step(); chk("sat_dn_c1", cnt(1), 32'd0); chk("sat_dn_t1", {31'd0, tc[1]}, 32'd0);
    step(); chk("sat_dn_c2", cnt(1), 32'd0); chk("sat_dn_t2", {31'd0, tc[1]}, 32'd1);
    step(); chk("sat_dn_c3", cnt(1), 32'd0); chk("sat_dn_t3", {31'd0, tc[1]}, 32'd1);

    // Load beats en and is clamped to limit
    mode = 1'b0; limit = 8'd100;
    load = 4'b0100; load_val = {8'd0, 8'd200, 8'd0, 8'd0}; en = 4'b0100; up = 4'b0100;
    step();
    chk("load_clamp_count", cnt(2), 32'd100);
    chk("load_clamp_tc", {31'd0, tc[2]}, 32'd0);
    load = 4'b0000;
    step();
    chk("wrap_from_limit_count", cnt(2), 32'd0);
    chk("wrap_from_limit_tc", {31'd0, tc[2]}, 32'd1);

    // Limit lowered below the count
    en = 4'b0000; load = 4'b1000; load_val = {8'd50, 8'd0, 8'd0, 8'd0};
    step();
    chk("load_ch3", cnt(3), 32'd50);
    chk("tc_clear_when_idle", {28'd0, tc}, 32'd0);
    load = 4'b0000; limit = 8'd10; en = 4'b1000; up = 4'b0000;
    step();
    chk("oor_clamp_count", cnt(3), 32'd10);
    chk("oor_clamp_tc", {31'd0, tc[3]}, 32'd0);
    step();
    chk("oor_next_count", cnt(3), 32'd9);

    // limit = 0 in both modes
    limit = 8'd0; up = 4'b1000; mode = 1'b1;
    step();
    chk("lim0_clamp_count", cnt(3), 32'd0);
    chk("lim0_clamp_tc", {31'd0, tc[3]}, 32'd0);
    step();
    chk("lim0_sat_up_count", cnt(3), 32'd0);
    chk("lim0_sat_up_tc", {31'd0, tc[3]}, 32'd1);
    mode = 1'b0; up = 4'b0000;
    step();
    chk("lim0_wrap_dn_count", cnt(3), 32'd0);
    chk("lim0_wrap_dn_tc", {31'd0, tc[3]}, 32'd1);

    // Mid-count reset with all channels active
    limit = 8'd200; mode = 1'b0;
    load = 4'hF; load_val = {8'd40, 8'd30, 8'd20, 8'd10}; en = 4'h0;
    step();
    load = 4'h0; en = 4'hF; up = 4'b0101;
    step();
    chk("all_count", count, {8'd39, 8'd31, 8'd19, 8'd11});
    rstn = 1'b0;
    step();
    chk("midreset_count", count, 32'd0);
    chk("midreset_tc", {28'd0, tc}, 32'd0);
    rstn = 1'b1;
    step();
    chk("resume_count", count, {8'd200, 8'd1, 8'd200, 8'd1});
    chk("resume_tc", {28'd0, tc}, 32'b1010);

`ifdef MOD_COUNTER_MC_WRAP_CNT_EN
    limit = 8'd1; mode = 1'b0; en = 4'b0001; up = 4'b0001;
    load = 4'b0001; load_val = 32'd0;
    step();
    chk("wcnt_cleared", {16'd0, wrap_cnt[15:0]}, 32'd0);
    load = 4'b0000;
    for (int i = 0; i < 10; i++) step();
    chk("wcnt_five", {16'd0, wrap_cnt[15:0]}, 32'd5);
    chk("wcnt_count", cnt(0), 32'd0);
    load = 4'b0001;
    step();
    chk("wcnt_load_clear", {16'd0, wrap_cnt[15:0]}, 32'd0);
    load = 4'b0000;
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
